fifo_width_down: RTL and testbench
==================================

# fifo_width_down

Parametrised single-clock FIFO that accepts wide write words and returns them as narrower read words. A write word is RATIO read words, most-significant sub-word first. It replaces the vendor asymmetric FIFO core in the AXI-Stream counter datapath, between the counter/packer and the stream output stage. It adds almost-full/almost-empty thresholds, overflow/underflow flags, a read valid strobe and occupancy counts on both sides.

## Interface
Parameters:
- RD_W, default 3: read data width in bits.
- RATIO, default 2: write-to-read width ratio, at least 2. Write width WR_W = RD_W*RATIO.
- DEPTH, default 16: capacity in write words. Must be a power of 2, at least 4.
- AF_THRESH, default DEPTH-2: almost_full asserts when wr_count >= AF_THRESH.
- AE_THRESH, default 2: almost_empty asserts when rd_count <= AE_THRESH.

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- din, in, WR_W: write data.
- wr_en, in, 1: write request.
- wr_ack, out, 1: write accepted in the previous cycle.
- overflow, out, 1: write rejected in the previous cycle because full.
- full, out, 1: DEPTH write words held.
- almost_full, out, 1: see AF_THRESH.
- wr_count, out, $clog2(DEPTH)+1: write words held, including a partially read word.
- rd_en, in, 1: read request.
- dout, out, RD_W: read data.
- valid, out, 1: dout updated by the read accepted in the previous cycle.
- underflow, out, 1: read rejected in the previous cycle because empty.
- empty, out, 1: no read words remain.
- almost_empty, out, 1: see AE_THRESH.
- rd_count, out, $clog2(DEPTH*RATIO)+1: read words remaining.

## Operation
- Write accepted when wr_en && !full. din is stored at wr_ptr and wr_ptr increments modulo DEPTH.
- Read accepted when rd_en && !empty. dout takes sub-word sub_idx of mem[rd_ptr]. Sub-word 0 is din[WR_W-1 -: RD_W], the MSB slice. Example: din 6'd12 reads out as 3'b001, then 3'b100.
- sub_idx counts 0..RATIO-1. On the last sub-word, sub_idx returns to 0 and rd_ptr increments modulo DEPTH; this frees the write slot.
- Pointers wrap silently. Occupancy comes from the counters, not from pointer comparison.
- wr_count increments on an accepted write and decrements when the last sub-word is read. Both in one cycle leaves it unchanged.
- rd_count changes by +RATIO on an accepted write and by -1 on an accepted read. Both in one cycle gives a net change of RATIO-1.
- Flags are derived from the registered counts: full = (wr_count==DEPTH), empty = (rd_count==0). A read in the same cycle does not relieve full for a concurrent write. A write in the same cycle does not relieve empty for a concurrent read.
- Rejected requests leave pointers, counts and memory unchanged.
- dout holds its last value when no read is accepted.

## Timing
- Reset (rst_n low, asynchronous):
  - Pointers, sub_idx and counts go to 0.
  - dout = 0; wr_ack, valid, overflow, underflow = 0.
  - empty = 1, almost_empty = 1; full = 0, almost_full = 0.
  - Memory contents are not reset.
- Reset mid-operation discards all stored data. The first write after rst_n rises is accepted on the first clock edge.
- Write to flags: wr_count, rd_count, full, empty and the almost flags update on the edge that accepts the write. A write at edge N makes empty low after edge N, and a read at edge N+1 is accepted.
- Read latency is 1: a read accepted at edge N presents dout and valid=1 after edge N.
- wr_ack, overflow, valid and underflow are single-cycle registered pulses.
- Back-to-back reads stream one sub-word per cycle. Back-to-back writes are accepted one per cycle until full.

## Structure
- Package fifo_pkg holds:
  - function cnt_w(int n) returning $clog2(n)+1;
  - a parameter legality check (DEPTH a power of 2, RATIO >= 2, thresholds in range), elaborated with $error.
- Sub-module fifo_sdp_ram: simple dual-port RAM, DEPTH x WR_W, synchronous write, asynchronous read address. It has no reset.
- The top level holds pointers, sub_idx, counters, flags and the output mux and register.

## Test plan
- Reset, then write din 12..27 (16 words) one per cycle -> 16 wr_ack pulses; full=1 after edge 16; almost_full=1 from wr_count 14; 17th write gives overflow=1, wr_ack=0, wr_count stays 16.
- Write 6'd12, then hold rd_en for 3 cycles -> dout 3'b001 then 3'b100 with valid=1 on both; third read gives underflow=1, empty=1, dout held at 3'b100.
- Fill to 16, read 1 sub-word, write in the same cycle as a second read -> write rejected (overflow=1); wr_count=15 after the second read.
- Half full with continuous wr_en and rd_en for 40 cycles -> wr_count and rd_count stay within bounds, and the read data equals the write data, MSB-first, across pointer wrap.
- Write 4 words, read 3 sub-words, pull rst_n low between edges -> outputs reach reset values immediately; rd_count=0; next write/read returns only the new data.
- RD_W=8, RATIO=4, DEPTH=8: write 32'hA1B2C3D4 -> reads A1, B2, C3, D4; rd_count goes 4, 3, 2, 1, 0; almost_empty follows AE_THRESH=2.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the width-down FIFO: counter sizing and parameter legality.
package fifo_pkg;

  function automatic int cnt_w(int n);
    return $clog2(n) + 1;
  endfunction

  function automatic bit params_ok(int rd_w, int ratio, int depth, int af, int ae);
    bit pow2;
    pow2 = (depth >= 4) && ((depth & (depth - 1)) == 0);
    return pow2 && (rd_w >= 1) && (ratio >= 2) &&
           (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae < depth * ratio);
  endfunction

endpackage

// File: rtl/fifo_width_down_if.sv
// Write/read bus of the width-down FIFO; slave is the FIFO side.
interface fifo_width_down_if #(
  parameter int RD_W  = 3,
  parameter int RATIO = 2,
  parameter int DEPTH = 16
) ();
  import fifo_pkg::*;
  localparam int WR_W = RD_W * RATIO;

  logic [WR_W-1:0]                   din;
  logic                              wr_en;
  logic                              wr_ack;
  logic                              overflow;
  logic                              full;
  logic                              almost_full;
  logic [cnt_w(DEPTH)-1:0]           wr_count;
  logic                              rd_en;
  logic [RD_W-1:0]                   dout;
  logic                              valid;
  logic                              underflow;
  logic                              empty;
  logic                              almost_empty;
  logic [cnt_w(DEPTH*RATIO)-1:0]     rd_count;

  modport slave (
    input  din, wr_en, rd_en,
    output wr_ack, overflow, full, almost_full, wr_count,
           dout, valid, underflow, empty, almost_empty, rd_count
  );

  modport master (
    output din, wr_en, rd_en,
    input  wr_ack, overflow, full, almost_full, wr_count,
           dout, valid, underflow, empty, almost_empty, rd_count
  );
endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: synchronous write, combinational read address.
module fifo_sdp_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 6,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_width_down.sv
// Single-clock FIFO taking WR_W-bit words and emitting RATIO RD_W-bit sub-words,
// MSB slice first, with registered status pulses and occupancy on both sides.
module fifo_width_down
  import fifo_pkg::*;
#(
  parameter int RD_W      = 3,
  parameter int RATIO     = 2,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic               clk,
  input logic               rst_n,
  fifo_width_down_if.slave  bus
);
  localparam int WR_W = RD_W * RATIO;
  localparam int PW   = $clog2(DEPTH);
  localparam int SW   = $clog2(RATIO);
  localparam int WCW  = cnt_w(DEPTH);
  localparam int RCW  = cnt_w(DEPTH * RATIO);

  if (!params_ok(RD_W, RATIO, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("fifo_width_down: illegal parameter combination");
  end

  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [SW-1:0]               sub_idx;
  logic [WCW-1:0]              wr_count;
  logic [RCW-1:0]              rd_count;
  logic [WR_W-1:0]             rd_word;
  logic [RATIO-1:0][RD_W-1:0]  sub_words;
  logic [RD_W-1:0]             dout_q;
  logic                        wr_ack_q, overflow_q, valid_q, underflow_q;
  logic                        full, empty, wr_acc, rd_acc, rd_last;

  // Flags come from the registered counts only, so same-cycle traffic on the
  // opposite side never relieves full or empty.
  assign full    = (wr_count == WCW'(DEPTH));
  assign empty   = (rd_count == '0);
  assign wr_acc  = bus.wr_en && !full;
  assign rd_acc  = bus.rd_en && !empty;
  assign rd_last = rd_acc && (sub_idx == SW'(RATIO - 1));

  fifo_sdp_ram #(.DEPTH(DEPTH), .WIDTH(WR_W)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .raddr (rd_ptr),
    .rdata (rd_word)
  );

  for (genvar i = 0; i < RATIO; i++) begin : g_sub
    assign sub_words[i] = rd_word[WR_W-1-i*RD_W -: RD_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sub_idx     <= '0;
      wr_count    <= '0;
      rd_count    <= '0;
      dout_q      <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) begin
        dout_q  <= sub_words[sub_idx];
        sub_idx <= rd_last ? '0 : sub_idx + SW'(1);
        if (rd_last) rd_ptr <= rd_ptr + PW'(1);
      end
      wr_count    <= wr_count + WCW'(wr_acc) - WCW'(rd_last);
      rd_count    <= rd_count + (wr_acc ? RCW'(RATIO) : RCW'(0)) - RCW'(rd_acc);
      wr_ack_q    <= wr_acc;
      overflow_q  <= bus.wr_en && full;
      valid_q     <= rd_acc;
      underflow_q <= bus.rd_en && empty;
    end
  end

  assign bus.wr_ack       = wr_ack_q;
  assign bus.overflow     = overflow_q;
  assign bus.full         = full;
  assign bus.almost_full  = (wr_count >= WCW'(AF_THRESH));
  assign bus.wr_count     = wr_count;
  assign bus.dout         = dout_q;
  assign bus.valid        = valid_q;
  assign bus.underflow    = underflow_q;
  assign bus.empty        = empty;
  assign bus.almost_empty = (rd_count <= RCW'(AE_THRESH));
  assign bus.rd_count     = rd_count;
endmodule

// File: tb/tb_fifo_width_down.sv
// Directed bench: queue-of-sub-words model checked every cycle on the default
// configuration, plus literal checks on both the default and a 8x4x8 instance.
module tb_fifo_width_down;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  fifo_width_down_if #(.RD_W(3), .RATIO(2), .DEPTH(16)) ifA ();
  fifo_width_down_if #(.RD_W(8), .RATIO(4), .DEPTH(8))  ifB ();

  fifo_width_down #(.RD_W(3), .RATIO(2), .DEPTH(16)) dA (.clk(clk), .rst_n(rst_n), .bus(ifA));
  fifo_width_down #(.RD_W(8), .RATIO(4), .DEPTH(8))  dB (.clk(clk), .rst_n(rst_n), .bus(ifB));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: FIFO of read sub-words; word occupancy is the sub-word count rounded up.
  int         mq[$];
  logic [2:0] m_dout;
  bit         m_valid, m_ack, m_ovf, m_unf;

  function automatic int words_of(int n);
    return (n + 1) / 2;
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_dout = '0; m_valid = 0; m_ack = 0; m_ovf = 0; m_unf = 0;
  endfunction

  function automatic void m_step();
    int n;
    bit wa, ra;
    n  = mq.size();
    wa = ifA.wr_en && (words_of(n) < 16);
    ra = ifA.rd_en && (n > 0);
    m_ack   = wa;
    m_ovf   = ifA.wr_en && !wa;
    m_valid = ra;
    m_unf   = ifA.rd_en && !ra;
    if (ra) m_dout = 3'(mq.pop_front());
    if (wa) begin
      mq.push_back(int'(ifA.din[5:3]));
      mq.push_back(int'(ifA.din[2:0]));
    end
  endfunction

  task automatic m_compare();
    int n, w;
    n = mq.size();
    w = words_of(n);
    chk("dout",         ifA.dout,         m_dout);
    chk("valid",        ifA.valid,        m_valid);
    chk("wr_ack",       ifA.wr_ack,       m_ack);
    chk("overflow",     ifA.overflow,     m_ovf);
    chk("underflow",    ifA.underflow,    m_unf);
    chk("wr_count",     ifA.wr_count,     w);
    chk("rd_count",     ifA.rd_count,     n);
    chk("full",         ifA.full,         w == 16);
    chk("almost_full",  ifA.almost_full,  w >= 14);
    chk("empty",        ifA.empty,        n == 0);
    chk("almost_empty", ifA.almost_empty, n <= 2);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) m_reset(); else m_step();
      @(negedge clk);
      if (!rst_n) m_reset();
      m_compare();
    end
  end

  task automatic stepA(input logic we, input logic [5:0] d, input logic re);
    ifA.wr_en = we; ifA.din = d; ifA.rd_en = re;
    @(posedge clk); #1;
  endtask

  task automatic stepB(input logic we, input logic [31:0] d, input logic re);
    ifB.wr_en = we; ifB.din = d; ifB.rd_en = re;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bexp [4];
    bexp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    ifA.wr_en = 0; ifA.din = '0; ifA.rd_en = 0;
    ifB.wr_en = 0; ifB.din = '0; ifB.rd_en = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty",  ifA.empty, 1);
    chk("rst_aempty", ifA.almost_empty, 1);
    chk("rst_full",   ifA.full, 0);
    chk("rst_dout",   ifA.dout, 0);
    chk("rst_rdcnt",  ifA.rd_count, 0);
    rst_n = 1'b1;

    // Fill with 12..27, then one write too many
    for (int i = 0; i < 16; i++) begin
      stepA(1, 6'(12 + i), 0);
      chk("fill_ack",   ifA.wr_ack, 1);
      chk("fill_afull", ifA.almost_full, i >= 13);
      chk("fill_full",  ifA.full, i == 15);
    end
    stepA(1, 6'd28, 0);
    chk("ovf_flag",  ifA.overflow, 1);
    chk("ovf_ack",   ifA.wr_ack, 0);
    chk("ovf_wrcnt", ifA.wr_count, 16);
    stepA(0, 0, 1);
    chk("drain_first", ifA.dout, 3'b001);
    repeat (31) stepA(0, 0, 1);
    chk("drain_last",  ifA.dout, 3'd3);
    chk("drain_empty", ifA.empty, 1);
    stepA(0, 0, 0);

    // Single word 12 read out MSB first, then underflow
    stepA(1, 6'd12, 0);
    chk("w12_rdcnt", ifA.rd_count, 2);
    stepA(0, 0, 1);
    chk("w12_sub0", ifA.dout, 3'b001);
    chk("w12_v0",   ifA.valid, 1);
    stepA(0, 0, 1);
    chk("w12_sub1", ifA.dout, 3'b100);
    chk("w12_v1",   ifA.valid, 1);
    stepA(0, 0, 1);
    chk("unf_flag",  ifA.underflow, 1);
    chk("unf_valid", ifA.valid, 0);
    chk("unf_empty", ifA.empty, 1);
    chk("unf_hold",  ifA.dout, 3'b100);

    // Full: concurrent read does not free room for a write
    for (int i = 0; i < 16; i++) stepA(1, 6'(40 + i), 0);
    stepA(0, 0, 1);
    chk("fr_sub0", ifA.dout, 3'd5);
    stepA(1, 6'd7, 1);
    chk("fr_ovf",   ifA.overflow, 1);
    chk("fr_ack",   ifA.wr_ack, 0);
    chk("fr_wrcnt", ifA.wr_count, 15);
    chk("fr_sub1",  ifA.dout, 3'd0);
    repeat (30) stepA(0, 0, 1);
    chk("fr_empty", ifA.empty, 1);

    // Streaming writes and reads across pointer wrap
    for (int i = 0; i < 8; i++) stepA(1, 6'(i * 5), 0);
    for (int i = 0; i < 40; i++) begin
      stepA(1, 6'(i * 7 + 3), 1);
      chk("stream_bound", ifA.wr_count <= 16, 1);
    end
    for (int k = 0; k < 80 && !ifA.empty; k++) stepA(0, 0, 1);
    chk("stream_drained", ifA.empty, 1);
    stepA(0, 0, 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) stepA(1, 6'(50 + i), 0);
    repeat (3) stepA(0, 0, 1);
    stepA(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout",   ifA.dout, 0);
    chk("arst_valid",  ifA.valid, 0);
    chk("arst_empty",  ifA.empty, 1);
    chk("arst_aempty", ifA.almost_empty, 1);
    chk("arst_rdcnt",  ifA.rd_count, 0);
    chk("arst_wrcnt",  ifA.wr_count, 0);
    stepA(0, 0, 0);
    stepA(0, 0, 0);
    rst_n = 1'b1;
    stepA(1, 6'd33, 0);
    chk("post_ack",   ifA.wr_ack, 1);
    chk("post_rdcnt", ifA.rd_count, 2);
    stepA(0, 0, 1);
    chk("post_sub0", ifA.dout, 3'd4);
    stepA(0, 0, 1);
    chk("post_sub1",  ifA.dout, 3'd1);
    chk("post_empty", ifA.empty, 1);

    // Wide configuration: 8-bit reads, ratio 4
    stepB(1, 32'hA1B2C3D4, 0);
    chk("b_ack",    ifB.wr_ack, 1);
    chk("b_rdcnt",  ifB.rd_count, 4);
    chk("b_wrcnt",  ifB.wr_count, 1);
    chk("b_aempty", ifB.almost_empty, 0);
    for (int k = 0; k < 4; k++) begin
      stepB(0, 0, 1);
      chk("b_dout",   ifB.dout, bexp[k]);
      chk("b_valid",  ifB.valid, 1);
      chk("b_rdcnt",  ifB.rd_count, 3 - k);
      chk("b_aempty", ifB.almost_empty, (3 - k) <= 2);
    end
    chk("b_empty", ifB.empty, 1);
    chk("b_wrcnt0", ifB.wr_count, 0);
    stepB(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
